ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave (responder) at the slave end of the interconnect: decodes one selected transfer per address phase, holds a
//  byte-enabled SRAM array, inserts programmable wait states and returns OKAY or the two-cycle ERROR response.
//  One instance hangs off each S_HSELX bit; HREADY_O/HRESP/HRDATA feed the interconnect response mux.
// PARAMETERS
//  DW          32    data bus width (32 or 64)
//  AW          32    address width
//  MEM_DEPTH   1024  array depth in DW-bit words; word index = HADDR[log2(DW/8)+:log2(MEM_DEPTH)]
//  WAIT_CYCLES 0     HREADY_O-low cycles inserted per OKAY transfer (0..15)
// PORTS
//  HCLK      in   1     clock
//  HRESET    in   1     reset, synchronous, active-high
//  HSEL      in   1     slave select from interconnect decoder
//  HADDR     in   AW    address
//  HTRANS    in   2     IDLE/BUSY/NONSEQ/SEQ
//  HWRITE    in   1     1=write
//  HSIZE     in   3     transfer size
//  HBURST    in   3     burst type (informational, not checked)
//  HWSTRB    in   DW/8  write byte strobes
//  HWDATA    in   DW    write data (data phase)
//  HREADY_I  in   1     bus HREADY (previous transfer finished)
//  HLOCK     in   1     locked sequence (no effect on slave)
//  HRDATA    out  DW    read data
//  HREADY_O  out  1     this slave's ready
//  HRESP     out  1     0=OKAY 1=ERROR
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset (and any HRESET mid-transfer): FSM->ST_IDLE, HREADY_O=1, HRESP=0, HRDATA=0, pending transfer dropped, no array
//  write. Array contents not reset.
//  Accept: address phase valid when HSEL & HREADY_I & HTRANS[1]; capture addr/write/size/byte-enable into regs.
//  IDLE/BUSY or HSEL=0 with HREADY_I=1: next cycle zero-wait OKAY, no access.
//  Error check at accept: word index >= MEM_DEPTH, HSIZE > log2(DW/8), or HADDR not aligned to HSIZE -> error path.
//  Byte enable = size_mask(HSIZE,HADDR low bits) & HWSTRB, captured in address phase.
//  FSM (registered):
//   ST_IDLE : HREADY_O=1,HRESP=0. Valid accept: error->ST_ERR1; WAIT_CYCLES>0->ST_WAIT (cnt=WAIT_CYCLES-1);
//             else ->ST_DATA.
//   ST_WAIT : HREADY_O=0,HRESP=0; cnt dec; cnt==0 ->ST_DATA. Inputs ignored (no new accept).
//   ST_DATA : HREADY_O=1,HRESP=0; write: array[idx] bytes <= HWDATA where be=1 at end of cycle; read: HRDATA=array[idx].
//             Same edge evaluates a pipelined accept (next state as from ST_IDLE; none ->ST_IDLE).
//   ST_ERR1 : HREADY_O=0,HRESP=1. Always ->ST_ERR2 (master IDLE cancel does not shorten it).
//   ST_ERR2 : HREADY_O=1,HRESP=1, no array access; pipelined accept evaluated as in ST_DATA.
//  Latency: OKAY transfer data phase = WAIT_CYCLES+1 cycles; ERROR = exactly 2 cycles.
//  Read-after-write, back-to-back same word: write commits at ST_DATA edge, array read is asynchronous, so read returns
//  new data; no stall.
//  HRDATA=0 outside a read ST_DATA cycle. HBURST/HLOCK never change timing; SEQ handled identically to NONSEQ.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS/HBURST/HSIZE/HRESP encodings (IDLE,BUSY,NONSEQ,SEQ,OKAY,ERROR,...), FSM state
//  encodings, function size_mask(hsize,addr_lo)->DW/8 byte mask.
//  Sub-module ahb_sram_bytemem: MEM_DEPTH x DW array, per-byte write enable, async read port.
//  Top: address-phase capture regs, wait counter, FSM, response/HRDATA muxing.
// TESTING
//  1 WAIT_CYCLES=0: write 0xDEADBEEF word @0x0, then read @0x0 back-to-back -> HREADY_O never low, HRDATA=0xDEADBEEF.
//  2 WAIT_CYCLES=2: read @0x10 -> HREADY_O=0 for 2 cycles, then 1 with correct data; HRESP=0 throughout.
//  3 HSIZE=byte write 0xAA @0x5 over 0x11223344 @0x4 -> readback 0x1122AA44; HSIZE=half @0x3 -> ERROR 0/1 then 1/1,
//    word unchanged.
//  4 Read @ MEM_DEPTH*DW/8 -> HREADY_O,HRESP = (0,1),(1,1); HTRANS=IDLE in ERR1 still gives ERR2.
//  5 HSEL=1,HTRANS=BUSY; then HSEL=0,HTRANS=NONSEQ -> zero-wait OKAY, array unchanged.
//  6 HRESET high during ST_WAIT of write @0x20 -> HREADY_O=1,HRESP=0 next cycle; readback @0x20 shows old data.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, responder FSM states and the byte-lane mask helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Widest supported bus is 64 bits, so masks are built 8 lanes wide and
    // the caller keeps the low DW/8 bits.
    localparam int MAX_STRB = 8;

    // Lanes touched by a transfer of 2**hsize bytes starting at lane addr_lo.
    function automatic logic [MAX_STRB-1:0] size_mask(input logic [2:0] hsize,
                                                      input logic [2:0] addr_lo);
        logic [15:0] m;
        case (hsize)
            3'd0:    m = 16'h0001;
            3'd1:    m = 16'h0003;
            3'd2:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << addr_lo;
        return m[MAX_STRB-1:0];
    endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Byte-laned SRAM array: one storage column per byte lane, per-lane write
// enable, asynchronous read so a write committed on an edge is visible to a
// read data phase in the very next cycle.
module ahb_sram_bytemem #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IDXW  = 10
) (
    input  logic            clk,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [IDXW-1:0] addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    for (genvar b = 0; b < DW/8; b++) begin : g_lane
        logic [7:0] arr [DEPTH];

        // Commit this lane when the word is written and the lane is enabled.
        always_ff @(posedge clk) begin
            if (we && be[b]) arr[addr] <= wdata[b*8 +: 8];
        end

        assign rdata[b*8 +: 8] = arr[addr];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder with a byte-enabled SRAM, programmable wait states and the
// two-cycle ERROR response. Address-phase attributes are captured into
// registers; the data phase is driven entirely from the registered state.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [AW-1:0]   HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [DW/8-1:0] HWSTRB,
    input  logic [DW-1:0]   HWDATA,
    input  logic            HREADY_I,
    input  logic            HLOCK,
    output logic [DW-1:0]   HRDATA,
    output logic            HREADY_O,
    output logic            HRESP
);

    localparam int NB   = DW / 8;
    localparam int BW   = $clog2(NB);
    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [IDXW-1:0]   idx_q;
    logic              wr_q;
    logic [NB-1:0]     be_q;

    logic              can_accept, accept, xfer_err;
    logic              range_err, size_err, align_err;
    logic [AW-1:0]     align_mask;
    logic [MAX_STRB-1:0] lane_mask;
    logic [NB-1:0]     be_d;
    logic [IDXW-1:0]   idx_d;
    logic [DW-1:0]     mem_rdata;
    logic              mem_we;
    logic              unused_ok;

    // Burst type, lock and the SEQ/NONSEQ distinction never affect timing.
    assign unused_ok = ^{HBURST, HLOCK, HTRANS[0], lane_mask};

    // Address-phase decode. Range is checked on the full word address so an
    // access just past the array cannot alias back onto word 0.
    always_comb begin
        range_err  = (HADDR >> BW) >= AW'(MEM_DEPTH);
        size_err   = HSIZE > 3'(BW);
        align_mask = (AW'(1) << HSIZE) - AW'(1);
        align_err  = |(HADDR & align_mask);
        xfer_err   = range_err | size_err | align_err;
        lane_mask  = size_mask(HSIZE, 3'(HADDR[BW-1:0]));
        be_d       = lane_mask[NB-1:0] & HWSTRB;
        idx_d      = HADDR[BW +: IDXW];
        can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
        accept     = can_accept && HSEL && HREADY_I && HTRANS[1];
    end

    // FSM and wait counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the accepted transfer's attributes for its data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q <= '0;
            wr_q  <= 1'b0;
            be_q  <= '0;
        end else if (accept) begin
            idx_q <= idx_d;
            wr_q  <= HWRITE;
            be_q  <= be_d;
        end
    end

    // Next state: the last cycle of every data phase doubles as an address
    // phase, so DATA and ERR2 re-evaluate accept exactly like IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_DATA;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response outputs decoded straight from the registered state.
    always_comb begin
        HREADY_O = !((state == ST_WAIT) || (state == ST_ERR1));
        HRESP    = (state == ST_ERR1) || (state == ST_ERR2);
        HRDATA   = ((state == ST_DATA) && !wr_q) ? mem_rdata : '0;
    end

    // A reset arriving in the data phase cancels the write.
    assign mem_we = (state == ST_DATA) && wr_q && !HRESET;

    ahb_sram_bytemem #(
        .DW    (DW),
        .DEPTH (MEM_DEPTH),
        .IDXW  (IDXW)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two responders (0 and 2 wait states) on one
// shared master, checked against a byte-array memory model.
module tb_ahb_sram_slave;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int NBYTE = DEPTH * 4;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sel, tgt, hwrite, hlock;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hwstrb;

    logic [31:0] rd0, rd2, obs_rd;
    logic        rdy0, rdy2, rsp0, rsp2, obs_rdy, obs_rsp;

    logic [7:0]  mref [2][NBYTE];
    int          ntests = 0;
    int          nfail  = 0;

    always #5 HCLK = ~HCLK;

    assign obs_rdy = tgt ? rdy2 : rdy0;
    assign obs_rsp = tgt ? rsp2 : rsp0;
    assign obs_rd  = tgt ? rd2  : rd0;

    ahb_sram_slave #(.DW(DW), .AW(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel & ~tgt), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWSTRB(hwstrb), .HWDATA(hwdata),
        .HREADY_I(rdy0), .HLOCK(hlock), .HRDATA(rd0), .HREADY_O(rdy0), .HRESP(rsp0));

    ahb_sram_slave #(.DW(DW), .AW(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel & tgt), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWSTRB(hwstrb), .HWDATA(hwdata),
        .HREADY_I(rdy2), .HLOCK(hlock), .HRDATA(rd2), .HREADY_O(rdy2), .HRESP(rsp2));

    // ---------------- reference model ----------------
    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        return ((a >> 2) >= DEPTH) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] mword(input bit t, input logic [31:0] a);
        int base = int'(a) & ~3;
        return {mref[t][base+3], mref[t][base+2], mref[t][base+1], mref[t][base]};
    endfunction

    task automatic mwrite(input bit t, input logic [31:0] a, input logic [2:0] sz,
                          input logic [3:0] st, input logic [31:0] d);
        int base = int'(a) & ~3;
        int lo   = int'(a) % 4;
        int n    = 1 << sz;
        if (!exp_err(a, sz))
            for (int b = 0; b < 4; b++)
                if (b >= lo && b < lo + n && st[b]) mref[t][base+b] = d[b*8 +: 8];
    endtask

    // Single non-pipelined transfer; reports what the bus showed in its data phase.
    task automatic xfer(input bit t, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [3:0] st, input logic [31:0] wd,
                        output int low, output bit rf, output bit rl, output bit ror,
                        output logic [31:0] rdl, output bit tmo);
        @(posedge HCLK); #1;
        tgt = t; sel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hwstrb = st;
        hburst = 3'($urandom); hlock = 1'($urandom);
        @(posedge HCLK); #1;
        sel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom;
        low = 0; rf = 0; rl = 0; ror = 0; rdl = '0; tmo = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge HCLK);
            if (c == 0) rf = obs_rsp;
            ror |= obs_rsp;
            if (obs_rdy) begin
                rl = obs_rsp; rdl = obs_rd; tmo = 1'b0;
                break;
            end
            low++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
            nfail++; $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h, want 1 0 0", rdy0, rsp0, rd0);
        end
        ntests++;
        if ({rdy2, rsp2, rd2} !== {1'b1, 1'b0, 32'h0}) begin
            nfail++; $display("FAIL reset_dut2: got rdy=%b resp=%b rdata=%h, want 1 0 0", rdy2, rsp2, rd2);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    task automatic preload();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl, d;
        for (int t = 0; t < 2; t++)
            for (int w = 0; w < DEPTH; w++) begin
                d = $urandom;
                xfer(t[0], 1'b1, 32'(w*4), 3'd2, 4'hF, d, low, rf, rl, ror, rdl, tmo);
                mwrite(t[0], 32'(w*4), 3'd2, 4'hF, d);
            end
    endtask

    task automatic test_b2b_rw();
        int lowseen = 0;
        @(posedge HCLK); #1;
        tgt = 0; sel = 1; htrans = 2'b10; haddr = 32'h0; hwrite = 1; hsize = 3'd2; hwstrb = 4'hF;
        @(negedge HCLK); if (!rdy0) lowseen++;
        @(posedge HCLK); #1;
        hwdata = 32'hDEADBEEF; hwrite = 0; haddr = 32'h0;
        @(negedge HCLK); if (!rdy0) lowseen++;
        ntests++;
        if ({rsp0, rd0} !== {1'b0, 32'h0}) begin
            nfail++; $display("FAIL b2b_wr_phase: got resp=%b rdata=%h, want 0 00000000", rsp0, rd0);
        end
        mwrite(0, 32'h0, 3'd2, 4'hF, 32'hDEADBEEF);
        @(posedge HCLK); #1;
        sel = 0; htrans = 2'b00;
        @(negedge HCLK); if (!rdy0) lowseen++;
        ntests++;
        if ({rsp0, rd0} !== {1'b0, 32'hDEADBEEF}) begin
            nfail++; $display("FAIL b2b_rd_data: got resp=%b rdata=%h, want 0 deadbeef", rsp0, rd0);
        end
        ntests++;
        if (lowseen != 0) begin
            nfail++; $display("FAIL b2b_hready: got %0d low cycles, want 0", lowseen);
        end
    endtask

    task automatic test_wait();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl;
        xfer(1, 1'b0, 32'h10, 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (tmo || low != 2 || ror) begin
            nfail++; $display("FAIL wait_timing: got low=%0d resp_any=%b tmo=%b, want 2 0 0", low, ror, tmo);
        end
        ntests++;
        if (rdl !== mword(1, 32'h10)) begin
            nfail++; $display("FAIL wait_rdata: got %h, want %h", rdl, mword(1, 32'h10));
        end
    endtask

    task automatic test_byte_lanes();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl;
        xfer(0, 1'b1, 32'h4, 3'd2, 4'hF, 32'h11223344, low, rf, rl, ror, rdl, tmo);
        mwrite(0, 32'h4, 3'd2, 4'hF, 32'h11223344);
        xfer(0, 1'b1, 32'h5, 3'd0, 4'hF, 32'h5555AA55, low, rf, rl, ror, rdl, tmo);
        mwrite(0, 32'h5, 3'd0, 4'hF, 32'h5555AA55);
        xfer(0, 1'b0, 32'h4, 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (rdl !== 32'h1122AA44 || rdl !== mword(0, 32'h4)) begin
            nfail++; $display("FAIL byte_write: got %h, want 1122aa44", rdl);
        end
        xfer(0, 1'b1, 32'h3, 3'd1, 4'hF, 32'hFFFFFFFF, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (tmo || low != 1 || !rf || !rl) begin
            nfail++; $display("FAIL half_misalign_err: got low=%0d resp1=%b resp2=%b, want 1 1 1", low, rf, rl);
        end
        xfer(0, 1'b0, 32'h4, 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (rdl !== 32'h1122AA44) begin
            nfail++; $display("FAIL err_no_write: got %h, want 1122aa44", rdl);
        end
    endtask

    task automatic test_range_err();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl;
        xfer(1, 1'b0, 32'(NBYTE), 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (tmo || low != 1 || !rf || !rl || rdl !== 32'h0) begin
            nfail++; $display("FAIL range_err: got low=%0d resp1=%b resp2=%b rdata=%h, want 1 1 1 0", low, rf, rl, rdl);
        end
        // Error followed by a transfer pipelined into the ERR2 cycle.
        @(posedge HCLK); #1;
        tgt = 0; sel = 1; htrans = 2'b10; haddr = 32'(NBYTE + 8); hwrite = 0; hsize = 3'd2;
        @(posedge HCLK); #1;
        sel = 0; htrans = 2'b00;
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0} !== 2'b01) begin
            nfail++; $display("FAIL err1_resp: got rdy=%b resp=%b, want 0 1", rdy0, rsp0);
        end
        @(posedge HCLK); #1;
        sel = 1; htrans = 2'b11; haddr = 32'h8; hwrite = 0; hsize = 3'd2;
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0} !== 2'b11) begin
            nfail++; $display("FAIL err2_resp: got rdy=%b resp=%b, want 1 1", rdy0, rsp0);
        end
        @(posedge HCLK); #1;
        sel = 0; htrans = 2'b00;
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0, rd0} !== {1'b1, 1'b0, mword(0, 32'h8)}) begin
            nfail++; $display("FAIL err2_pipelined_read: got rdy=%b resp=%b rdata=%h, want 1 0 %h",
                              rdy0, rsp0, rd0, mword(0, 32'h8));
        end
    endtask

    task automatic test_idle_busy();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl;
        @(posedge HCLK); #1;
        tgt = 0; sel = 1; htrans = 2'b01; haddr = 32'h0; hwrite = 1; hsize = 3'd2; hwstrb = 4'hF;
        @(posedge HCLK); #1;
        sel = 0; htrans = 2'b10; hwdata = $urandom;
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
            nfail++; $display("FAIL busy_okay: got rdy=%b resp=%b rdata=%h, want 1 0 0", rdy0, rsp0, rd0);
        end
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = $urandom;
        @(negedge HCLK);
        ntests++;
        if ({rdy0, rsp0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
            nfail++; $display("FAIL unsel_okay: got rdy=%b resp=%b rdata=%h, want 1 0 0", rdy0, rsp0, rd0);
        end
        xfer(0, 1'b0, 32'h0, 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (rdl !== mword(0, 32'h0)) begin
            nfail++; $display("FAIL idle_no_write: got %h, want %h", rdl, mword(0, 32'h0));
        end
    endtask

    task automatic test_reset_wait();
        int low; bit rf, rl, ror, tmo; logic [31:0] rdl, nd;
        nd = ~mword(1, 32'h20);
        @(posedge HCLK); #1;
        tgt = 1; sel = 1; htrans = 2'b10; haddr = 32'h20; hwrite = 1; hsize = 3'd2; hwstrb = 4'hF;
        @(posedge HCLK); #1;
        sel = 0; htrans = 2'b00; hwdata = nd; HRESET = 1'b1;
        @(negedge HCLK);
        ntests++;
        if (rdy2 !== 1'b0) begin
            nfail++; $display("FAIL rst_wait_entered: got rdy=%b, want 0", rdy2);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        ntests++;
        if ({rdy2, rsp2} !== 2'b10) begin
            nfail++; $display("FAIL rst_wait_resp: got rdy=%b resp=%b, want 1 0", rdy2, rsp2);
        end
        repeat (4) @(posedge HCLK);
        xfer(1, 1'b0, 32'h20, 3'd2, 4'hF, 32'h0, low, rf, rl, ror, rdl, tmo);
        ntests++;
        if (rdl !== mword(1, 32'h20)) begin
            nfail++; $display("FAIL rst_wait_nowrite: got %h, want %h", rdl, mword(1, 32'h20));
        end
    endtask

    task automatic test_random();
        int low; bit rf, rl, ror, tmo, t, wr, e; logic [31:0] rdl, a, wd, expd;
        logic [2:0] sz; logic [3:0] st;
        for (int i = 0; i < 80; i++) begin
            t  = 1'($urandom);
            wr = 1'($urandom);
            sz = 3'($urandom_range(0, 3));
            a  = $urandom_range(0, NBYTE + 31);
            if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 1);
            st = 4'($urandom);
            wd = $urandom;
            e  = exp_err(a, sz);
            expd = (e || wr) ? 32'h0 : mword(t, a);
            xfer(t, wr, a, sz, st, wd, low, rf, rl, ror, rdl, tmo);
            ntests++;
            if (tmo || (e && (low != 1 || !rf || !rl)) || (!e && (low != (t ? 2 : 0) || ror))) begin
                nfail++; $display("FAIL rand_resp[%0d]: a=%h sz=%0d got low=%0d r1=%b r2=%b rany=%b tmo=%b, want err=%b",
                                  i, a, sz, low, rf, rl, ror, tmo, e);
            end
            ntests++;
            if (rdl !== expd) begin
                nfail++; $display("FAIL rand_rdata[%0d]: a=%h got %h, want %h", i, a, rdl, expd);
            end
            if (wr) mwrite(t, a, sz, st, wd);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        logic [31:0] a [N]; logic [31:0] wd [N]; logic [2:0] sz [N]; logic [3:0] st [N]; bit wr [N];
        logic [31:0] expd;
        for (int i = 0; i < N; i++) begin
            sz[i] = 3'($urandom_range(0, 2));
            a[i]  = $urandom_range(0, 15) & ~((32'd1 << sz[i]) - 1);
            wd[i] = $urandom; st[i] = 4'($urandom); wr[i] = 1'($urandom);
        end
        for (int i = 0; i <= N; i++) begin
            @(posedge HCLK); #1;
            tgt = 0;
            if (i < N) begin
                sel = 1; htrans = 2'($urandom_range(2, 3)); haddr = a[i]; hwrite = wr[i];
                hsize = sz[i]; hwstrb = st[i];
            end else begin
                sel = 0; htrans = 2'b00;
            end
            if (i > 0) hwdata = wd[i-1];
            @(negedge HCLK);
            if (i > 0) begin
                expd = wr[i-1] ? 32'h0 : mword(0, a[i-1]);
                ntests++;
                if ({rdy0, rsp0, rd0} !== {1'b1, 1'b0, expd}) begin
                    nfail++; $display("FAIL b2b_stream[%0d]: got rdy=%b resp=%b rdata=%h, want 1 0 %h",
                                      i-1, rdy0, rsp0, rd0, expd);
                end
                if (wr[i-1]) mwrite(0, a[i-1], sz[i-1], st[i-1], wd[i-1]);
            end
        end
    endtask

    initial begin
        HRESET = 1'b1; sel = 0; tgt = 0; htrans = 2'b00; haddr = '0; hwrite = 0;
        hsize = 3'd2; hburst = 3'd0; hwstrb = 4'hF; hwdata = '0; hlock = 0;
        test_reset();
        preload();
        test_b2b_rw();
        test_wait();
        test_byte_lanes();
        test_range_err();
        test_idle_busy();
        test_reset_wait();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
